// File: rtl/instr_issue_queue.sv
// Dual-issue in-order instruction queue between fetch and decode.
// Slot 1 issues only with slot 0, and only when it is independent of slot 0 and slot 0 is not a branch or jump.
module instr_issue_queue #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] in_instr,
  input  logic        ready0,
  input  logic        ready1,
  output logic [31:0] issue0_instr,
  output logic        issue0_valid,
  output logic [31:0] issue1_instr,
  output logic        issue1_valid,
  output logic [3:0]  count,
  output logic        almost_full,
  output logic        overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - 2);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_p1;
  logic [CW-1:0] cnt;

  logic [31:0] slot0, slot1;
  logic [4:0]  rd0, rs1_1, rs2_1;
  logic        hazard, branch0;
  logic        non_bubble, full, push, drop;
  logic        pop0, pop1;
  logic [1:0]  pop_cnt;

  always_comb begin
    rd_ptr_p1 = rd_ptr + PW'(1);
    slot0     = mem[rd_ptr];
    slot1     = mem[rd_ptr_p1];
    rd0       = slot0[11:7];
    rs1_1     = slot1[19:15];
    rs2_1     = slot1[24:20];
    hazard    = (rd0 != 5'd0) && ((rd0 == rs1_1) || (rd0 == rs2_1));
    branch0   = (slot0[6:0] == OP_BRANCH) || (slot0[6:0] == OP_JAL) ||
                (slot0[6:0] == OP_JALR);

    issue0_valid = (cnt >= CW'(1));
    issue1_valid = (cnt >= CW'(2)) && !hazard && !branch0;
    issue0_instr = issue0_valid ? slot0 : 32'd0;
    issue1_instr = issue1_valid ? slot1 : 32'd0;

    pop0    = issue0_valid & ready0;
    pop1    = pop0 & issue1_valid & ready1;
    pop_cnt = {1'b0, pop0} + {1'b0, pop1};

    // Fullness uses the pre-pop count: no push-through bypass when a pop frees a slot.
    non_bubble = (in_instr != 32'd0);
    full       = (cnt == FULL_CNT);
    push       = non_bubble && !full && !flush && !reset;
    drop       = non_bubble && full && !flush;
  end

  // NOTE: storage has no reset; entries beyond count are never observed, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      cnt    <= cnt + CW'(push) - CW'(pop_cnt);
      if (drop) overflow <= 1'b1;
    end
  end

  always_comb begin
    count       = 4'(cnt);
    almost_full = (cnt >= AF_CNT);
  end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Self-checking bench for instr_issue_queue: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_instr_issue_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0, flush = 1'b0, ready0 = 1'b0, ready1 = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] issue0_instr, issue1_instr;
  logic        issue0_valid, issue1_valid, almost_full, overflow;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  instr_issue_queue #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_instr(in_instr),
    .ready0(ready0), .ready1(ready1),
    .issue0_instr(issue0_instr), .issue0_valid(issue0_valid),
    .issue1_instr(issue1_instr), .issue1_valid(issue1_valid),
    .count(count), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of words in program order plus a sticky flag.
  logic [31:0] q[$];
  logic        m_ovf = 1'b0;

  function automatic logic m_dual_ok();
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        hz, br;
    if (q.size() < 2) return 1'b0;
    a  = q[0];
    b  = q[1];
    rd = a[11:7];
    hz = (rd != 0) && (rd == b[19:15] || rd == b[24:20]);
    br = (a[6:0] == 7'h63) || (a[6:0] == 7'h6F) || (a[6:0] == 7'h67);
    return !hz && !br;
  endfunction

  task automatic model_step(input logic rs, fl, input logic [31:0] ins, input logic r0, r1);
    int  n;
    logic p0, p1;
    n = q.size();
    if (rs) begin
      q.delete();
      m_ovf = 1'b0;
    end else if (fl) begin
      q.delete();
    end else begin
      p0 = (n >= 1) && r0;
      p1 = p0 && m_dual_ok() && r1;
      if (ins != 0 && n == 8) m_ovf = 1'b1;
      if (p0) void'(q.pop_front());
      if (p1) void'(q.pop_front());
      if (ins != 0 && n < 8) q.push_back(ins);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic v1;
    v1 = m_dual_ok();
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".v0"}, 32'(issue0_valid), 32'(q.size() >= 1));
    check({tag, ".i0"}, issue0_instr, (q.size() >= 1) ? q[0] : 32'd0);
    check({tag, ".v1"}, 32'(issue1_valid), 32'(v1));
    check({tag, ".i1"}, issue1_instr, v1 ? q[1] : 32'd0);
    check({tag, ".af"}, 32'(almost_full), 32'(q.size() >= 6));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic cycle(input logic rs, fl, input logic [31:0] ins, input logic r0, r1);
    reset = rs; flush = fl; in_instr = ins; ready0 = r0; ready1 = r1;
    model_step(rs, fl, ins, r0, r1);
    @(posedge clk);
    #1;
    reset = 1'b0; flush = 1'b0; in_instr = 32'd0; ready0 = 1'b0; ready1 = 1'b0;
  endtask

  typedef struct {
    logic        rst, fl;
    logic [31:0] instr;
    logic        r0, r1;
    logic [3:0]  e_count;
    logic        e_v0;
    logic [31:0] e_i0;
    logic        e_v1;
    logic [31:0] e_i1;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [31:0] addi0(input int k);
    return (32'(k) << 20) | 32'h13;
  endfunction

  initial begin
    //            rst   fl   instr          r0    r1   cnt  v0   i0             v1   i1             ovf
    tbl[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h00500093, 1'b0, 1'b0, 4'd1, 1'b1, 32'h00500093, 1'b0, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h00308113, 1'b0, 1'b0, 4'd2, 1'b1, 32'h00500093, 1'b0, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 4'd1, 1'b1, 32'h00308113, 1'b0, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 4'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'h00100093, 1'b0, 1'b0, 4'd1, 1'b1, 32'h00100093, 1'b0, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h00200113, 1'b0, 1'b0, 4'd2, 1'b1, 32'h00100093, 1'b1, 32'h00200113, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 4'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0000006F, 1'b0, 1'b0, 4'd1, 1'b1, 32'h0000006F, 1'b0, 32'h0,        1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h00100093, 1'b0, 1'b0, 4'd2, 1'b1, 32'h0000006F, 1'b0, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 4'd1, 1'b1, 32'h00100093, 1'b0, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 4'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};

    #1;
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].rst, tbl[i].fl, tbl[i].instr, tbl[i].r0, tbl[i].r1);
      check($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].e_count));
      check($sformatf("vec%0d.v0", i), 32'(issue0_valid), 32'(tbl[i].e_v0));
      check($sformatf("vec%0d.i0", i), issue0_instr, tbl[i].e_i0);
      check($sformatf("vec%0d.v1", i), 32'(issue1_valid), 32'(tbl[i].e_v1));
      check($sformatf("vec%0d.i1", i), issue1_instr, tbl[i].e_i1);
      check($sformatf("vec%0d.af", i), 32'(almost_full), 32'(0));
      check($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
    end

    // Nine pushes with no ready: the ninth is dropped and the flag sticks through a flush.
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b0, 1'b0, 32'hA000_0000 + 32'(k), 1'b0, 1'b0);
      check($sformatf("fill%0d.count", k), 32'(count), (k > 8) ? 32'd8 : 32'(k));
      check($sformatf("fill%0d.af", k), 32'(almost_full), 32'(k >= 6));
      check($sformatf("fill%0d.ovf", k), 32'(overflow), 32'(k == 9));
    end
    check("fill.head", issue0_instr, 32'hA000_0001);
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    check("flush.count", 32'(count), 32'd0);
    check("flush.v0", 32'(issue0_valid), 32'd0);
    check("flush.ovf_sticky", 32'(overflow), 32'd1);

    // Full queue, then push one / pop two per cycle until the read pointer wraps.
    for (int k = 1; k <= 8; k++) cycle(1'b0, 1'b0, addi0(k), 1'b0, 1'b0);
    check_model("wrapfill");
    for (int c = 1; c <= 6; c++) begin
      cycle(1'b0, 1'b0, addi0(8 + c), 1'b1, 1'b1);
      check($sformatf("wrap%0d.count", c), 32'(count), 32'(7 - c));
      check_model($sformatf("wrap%0d", c));
    end
    check("wrap.last", issue0_instr, addi0(14));

    // Flush and push together at count 5, then reset together with flush.
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) cycle(1'b0, 1'b0, 32'hC000_0000 + 32'(k), 1'b0, 1'b0);
    check("pre_flush.count", 32'(count), 32'd5);
    cycle(1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b1);
    check("flush_push.count", 32'(count), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("flush_push.not_stored", 32'(issue0_valid), 32'd0);
    check("flush_push.ovf", 32'(overflow), 32'd1);
    cycle(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    check("rst_flush.ovf", 32'(overflow), 32'd0);
    check_model("rst_flush");

    // Mid-operation reset discards queued entries.
    for (int k = 1; k <= 3; k++) cycle(1'b0, 1'b0, addi0(k), 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h5555_5555, 1'b1, 1'b1);
    check("mid_reset.count", 32'(count), 32'd0);
    check_model("mid_reset");

    // Random traffic with small register numbers so hazards and branches are frequent.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] w;
      logic [6:0]  op;
      case ($urandom_range(0, 4))
        0: op = 7'h63;
        1: op = 7'h6F;
        2: op = 7'h67;
        3: op = 7'h33;
        default: op = 7'h13;
      endcase
      w = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           3'($urandom), 5'($urandom_range(0, 3)), op};
      if ($urandom_range(0, 9) < 3) w = 32'd0;
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0, w,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
